// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and widths for the pipeline hazard controller.
//   hz_state_e : controller state encoding (RUN / FLUSH / MEM_WAIT)
//   hz_ctrl_t  : bundle of the six stall/flush controls driven to the pipe regs
//   sat_inc8   : saturating 8-bit increment used by the memory-wait watchdog
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int PERF_CNT_W  = 32;
  localparam int BUSY_CNT_W  = 8;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_exe_stall;
    logic id_exe_flush;
    logic exe_mem_stall;
  } hz_ctrl_t;

  function automatic logic [BUSY_CNT_W-1:0] sat_inc8(input logic [BUSY_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: single 32-bit event counter that sticks at all-ones.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   en  : count this cycle
//   cnt : current count
module hazard_perf_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [PERF_CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the PC, IF/ID, ID/EXE and EXE/MEM regs.
//   - load-use stall between the ID instruction and the load in ID/EXE
//   - FLUSH_CYCLES-long flush of IF/ID and ID/EXE after a taken EXE branch
//   - full-pipe freeze while data memory is busy, with a sticky watchdog
// Ports:
//   clk_i, rst_i (sync, active-high)
//   id_reg_addr_1_i/_2_i, id_rs1_used_i/id_rs2_used_i : ID source operands
//   ex_MemRead_i, ex_reg_dest_i                       : load info from ID/EXE
//   ex_branch_taken_i                                 : EXE branch resolved taken
//   mem_busy_i                                        : MEM stage must hold
//   *_stall_o / *_flush_o                             : pipe register controls (comb)
//   mem_timeout_o                                     : sticky watchdog (registered)
// Optional: define HAZARD_PERF_EN to add perf_lu_cnt_o, perf_flush_cnt_o and
// perf_wait_cnt_o (saturating 32-bit cycle counters).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_reg_addr_1_i,
  input  logic [REG_ADDR_W-1:0] id_reg_addr_2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_MemRead_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_busy_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_exe_stall_o,
  output logic                  id_exe_flush_o,
  output logic                  exe_mem_stall_o,
`ifdef HAZARD_PERF_EN
  output logic [PERF_CNT_W-1:0] perf_lu_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_wait_cnt_o,
`endif
  output logic                  mem_timeout_o
);

  hz_state_e              state, state_nxt, eff_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [BUSY_CNT_W-1:0]  busy_cnt, busy_cnt_nxt;
  logic                   lu;
  hz_ctrl_t               ctrl;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = ex_MemRead_i && (ex_reg_dest_i != '0) &&
              ((id_rs1_used_i && id_reg_addr_1_i == ex_reg_dest_i) ||
               (id_rs2_used_i && id_reg_addr_2_i == ex_reg_dest_i));

  // Once memory releases, MEM_WAIT resolves within the same cycle to the state
  // it interrupted, so the RUN/FLUSH rules apply without a dead cycle.
  always_comb begin
    eff_state = state;
    if (state == HZ_MEM_WAIT)
      eff_state = (flush_cnt != '0) ? HZ_FLUSH : HZ_RUN;
  end

  // State register and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= HZ_RUN;
      flush_cnt     <= '0;
      busy_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      busy_cnt  <= busy_cnt_nxt;
      if (mem_busy_i && busy_cnt_nxt == BUSY_CNT_W'(MEM_TIMEOUT))
        mem_timeout_o <= 1'b1;
    end
  end

  // Next state. A busy memory suspends a flush in progress: flush_cnt is held.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    busy_cnt_nxt  = busy_cnt;
    if (mem_busy_i) begin
      state_nxt    = HZ_MEM_WAIT;
      busy_cnt_nxt = sat_inc8(busy_cnt);
    end else begin
      busy_cnt_nxt = '0;
      if (eff_state == HZ_FLUSH) begin
        flush_cnt_nxt = flush_cnt - 1'b1;
        state_nxt     = (flush_cnt == FLUSH_CNT_W'(1)) ? HZ_RUN : HZ_FLUSH;
      end else begin
        state_nxt = HZ_RUN;
        if (ex_branch_taken_i && FLUSH_CYCLES > 1) begin
          flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          state_nxt     = HZ_FLUSH;
        end
      end
    end
  end

  // Outputs. Branch flushes win over load-use: the dependent instruction is on
  // the wrong path anyway. During FLUSH, EXE holds a bubble so branch is moot.
  always_comb begin
    ctrl = '0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        ctrl.pc_stall      = 1'b1;
        ctrl.if_id_stall   = 1'b1;
        ctrl.id_exe_stall  = 1'b1;
        ctrl.exe_mem_stall = 1'b1;
      end else if (eff_state == HZ_FLUSH || ex_branch_taken_i) begin
        ctrl.if_id_flush   = 1'b1;
        ctrl.id_exe_flush  = 1'b1;
      end else if (lu) begin
        ctrl.pc_stall      = 1'b1;
        ctrl.if_id_stall   = 1'b1;
        ctrl.id_exe_flush  = 1'b1;
      end
    end
  end

  assign pc_stall_o      = ctrl.pc_stall;
  assign if_id_stall_o   = ctrl.if_id_stall;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_exe_stall_o  = ctrl.id_exe_stall;
  assign id_exe_flush_o  = ctrl.id_exe_flush;
  assign exe_mem_stall_o = ctrl.exe_mem_stall;

`ifdef HAZARD_PERF_EN
  logic lu_cyc;
  assign lu_cyc = ctrl.pc_stall && !ctrl.exe_mem_stall;

  hazard_perf_cnt u_perf_lu (
    .clk (clk_i), .rst (rst_i), .en (lu_cyc),             .cnt (perf_lu_cnt_o)
  );
  hazard_perf_cnt u_perf_flush (
    .clk (clk_i), .rst (rst_i), .en (ctrl.if_id_flush),   .cnt (perf_flush_cnt_o)
  );
  hazard_perf_cnt u_perf_wait (
    .clk (clk_i), .rst (rst_i), .en (ctrl.exe_mem_stall), .cnt (perf_wait_cnt_o)
  );
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall and flush controls consumed by the PC, IF/ID, ID/EXE and EXE/MEM registers.
- Detects load-use hazards between the instruction in ID and the load held in ID/EXE.
- Issues multi-cycle flushes on taken branches resolved in EXE.
- Freezes the whole pipe while data memory is busy, with a watchdog timeout.
- Sits beside the ID/EXE register: reads its outputs and feeds back its flush (bubble) control.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID and ID/EXE are flushed after a taken branch (1..7).
- MEM_TIMEOUT, 255, busy cycles after which mem_timeout_o is raised (1..255); 8-bit counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high (`RstEnable = 1'b1)
- id_reg_addr_1_i  in  `RegAddrBus (5)  rs1 of instruction in ID
- id_reg_addr_2_i  in  `RegAddrBus (5)  rs2 of instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_MemRead_i  in  1  MemRead from ID/EXE outputs
- ex_reg_dest_i  in  `RegAddrBus (5)  rd from ID/EXE outputs
- ex_branch_taken_i  in  1  branch resolved taken in EXE this cycle
- mem_busy_i  in  1  data memory not ready; MEM stage must hold
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID
- if_id_flush_o  out  1  load NOP into IF/ID
- id_exe_stall_o  out  1  hold ID/EXE
- id_exe_flush_o  out  1  load bubble (all control signals zero) into ID/EXE
- exe_mem_stall_o  out  1  hold EXE/MEM
- mem_timeout_o  out  1  sticky watchdog error

Behaviour:
- All outputs are combinational from current state and inputs, except mem_timeout_o, which is registered.
- Reset: state=RUN, flush counter=0, busy counter=0, mem_timeout_o=0. While rst_i is high, all stall/flush outputs are 0.
- Reset mid-operation discards any pending flush or wait on the next edge.
- States: RUN, FLUSH, MEM_WAIT.
- Load-use (lu) = ex_MemRead_i & (ex_reg_dest_i != 0) & ((id_rs1_used_i & id_reg_addr_1_i == ex_reg_dest_i) | (id_rs2_used_i & id_reg_addr_2_i == ex_reg_dest_i)). Register x0 never causes a hazard.
- Priority per cycle: mem_busy_i > branch/FLUSH > lu.
- mem_busy_i=1, in any state:
  - pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o = 1; no flush outputs.
  - Next state is MEM_WAIT; a FLUSH in progress is suspended, and its counter is kept.
- MEM_WAIT:
  - Busy counter increments each busy cycle and saturates at 255.
  - When counter == MEM_TIMEOUT, mem_timeout_o is set and stays set until reset.
  - When mem_busy_i falls: counter clears; return to FLUSH if the flush counter is nonzero, else RUN.
  - The same cycle is then evaluated by the RUN/FLUSH rules.
- RUN with ex_branch_taken_i=1:
  - if_id_flush_o = id_exe_flush_o = 1, pc not stalled, so the target is loaded. Any lu is ignored (wrong-path).
  - If FLUSH_CYCLES > 1: flush counter = FLUSH_CYCLES-1, next state FLUSH.
- FLUSH:
  - if_id_flush_o = id_exe_flush_o = 1; counter decrements.
  - When the counter reaches 0, return to RUN. ex_branch_taken_i is ignored here because EXE holds a bubble.
- RUN with lu=1 and no branch:
  - pc_stall_o = if_id_stall_o = id_exe_flush_o = 1 for exactly one cycle.
  - The next cycle re-evaluates; lu is false because ID/EXE now holds a bubble.
- Flush and stall of the same register are never both 1.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs perf_lu_cnt_o, perf_flush_cnt_o and perf_wait_cnt_o (each 32 bits, saturating, reset to 0). They count lu-stall cycles, branch-flush cycles and memory-wait cycles respectively.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- define.v gains: `HzStateBus (2 bits), `HzRun, `HzFlush and `HzMemWait encodings, and `PerfCntBus (32 bits).
- Existing `RstEnable, `RegAddrBus and `ZeroSignal are reused.
- One sub-module, hazard_perf_cnt: a single saturating 32-bit counter with enable, instantiated three times under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_MemRead_i=1, ex_reg_dest_i=5, id_reg_addr_1_i=5, id_rs1_used_i=1 -> pc_stall_o = if_id_stall_o = id_exe_flush_o = 1 for exactly 1 cycle. Repeat with rd=0 -> no stall.
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken_i pulse -> if_id_flush_o = id_exe_flush_o = 1 for 2 consecutive cycles, pc_stall_o=0 throughout.
- Branch and lu in the same cycle -> flush only, pc_stall_o=0.
- mem_busy_i high for 3 cycles during the FLUSH state (FLUSH_CYCLES=3) -> all four stalls high for 3 cycles, no flushes; the remaining flush cycles resume afterwards.
- MEM_TIMEOUT=4, mem_busy_i held high for 6 cycles -> mem_timeout_o rises after the 4th busy cycle and stays high after busy drops; clears only on rst_i.
- rst_i asserted in the middle of FLUSH -> all outputs 0 at the next edge, state RUN. With HAZARD_PERF_EN, all counters read 0.
